// File: rtl/wb_regfile.sv
// Writeback stage: picks the writeback value, commits it to an 8x16 register file,
// serves two bypassed read ports and counts retired register writes.
module wb_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] wb_memData_i,
  input  logic [DATA_W-1:0] wb_aluResult_i,
  input  logic [ADDR_W-1:0] wb_reg3_i,
  input  logic              wb_resultOrMem_i,
  input  logic              wb_regWrite_i,
  input  logic [ADDR_W-1:0] id_raddr1_i,
  input  logic [ADDR_W-1:0] id_raddr2_i,
  output logic [DATA_W-1:0] id_rdata1_o,
  output logic [DATA_W-1:0] id_rdata2_o,
  output logic              fwd_wen_o,
  output logic [ADDR_W-1:0] fwd_waddr_o,
  output logic [DATA_W-1:0] fwd_wdata_o,
  output logic [CNT_W-1:0]  retired_cnt_o
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  retired_cnt;

  assign wdata = wb_resultOrMem_i ? wb_memData_i : wb_aluResult_i;

  // Storage and retired-write counter; every register including R0 is writable.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      retired_cnt <= '0;
    end else if (wb_regWrite_i) begin
      regs[wb_reg3_i] <= wdata;
      retired_cnt     <= retired_cnt + CNT_W'(1);
    end
  end

  assign retired_cnt_o = retired_cnt;

  // Read ports see the value being written this cycle; reset forces everything quiet.
  always_comb begin
    id_rdata1_o = '0;
    id_rdata2_o = '0;
    fwd_wen_o   = 1'b0;
    fwd_waddr_o = '0;
    fwd_wdata_o = '0;
    if (rst_i) begin
      id_rdata1_o = (wb_regWrite_i && (id_raddr1_i == wb_reg3_i)) ? wdata : regs[id_raddr1_i];
      id_rdata2_o = (wb_regWrite_i && (id_raddr2_i == wb_reg3_i)) ? wdata : regs[id_raddr2_i];
      fwd_wen_o   = wb_regWrite_i;
      fwd_waddr_o = wb_reg3_i;
      fwd_wdata_o = wdata;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table through a scoreboard queue,
// plus reset, idle-write and counter-wrap sequences.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] wb_memData_i, wb_aluResult_i;
  logic [2:0]  wb_reg3_i;
  logic        wb_resultOrMem_i, wb_regWrite_i;
  logic [2:0]  id_raddr1_i, id_raddr2_i;
  logic [15:0] id_rdata1_o, id_rdata2_o;
  logic        fwd_wen_o;
  logic [2:0]  fwd_waddr_o;
  logic [15:0] fwd_wdata_o;
  logic [15:0] retired_cnt_o;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_memData_i(wb_memData_i), .wb_aluResult_i(wb_aluResult_i),
    .wb_reg3_i(wb_reg3_i), .wb_resultOrMem_i(wb_resultOrMem_i),
    .wb_regWrite_i(wb_regWrite_i),
    .id_raddr1_i(id_raddr1_i), .id_raddr2_i(id_raddr2_i),
    .id_rdata1_o(id_rdata1_o), .id_rdata2_o(id_rdata2_o),
    .fwd_wen_o(fwd_wen_o), .fwd_waddr_o(fwd_waddr_o), .fwd_wdata_o(fwd_wdata_o),
    .retired_cnt_o(retired_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rw;
    logic        rom;
    logic [2:0]  reg3;
    logic [15:0] mem;
    logic [15:0] alu;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [15:0] e_rd1;
    logic [15:0] e_rd2;
    logic        e_wen;
    logic [2:0]  e_waddr;
    logic [15:0] e_wdata;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] rd1, rd2;
    logic        wen;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rw, input logic rom, input logic [2:0] reg3,
                       input logic [15:0] mem, input logic [15:0] alu,
                       input logic [2:0] ra1, input logic [2:0] ra2);
    wb_regWrite_i    = rw;
    wb_resultOrMem_i = rom;
    wb_reg3_i        = reg3;
    wb_memData_i     = mem;
    wb_aluResult_i   = alu;
    id_raddr1_i      = ra1;
    id_raddr2_i      = ra2;
  endtask

  task automatic read_reg(input string name, input logic [2:0] r, input logic [15:0] exp);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, r, r);
    #1;
    check({name, "_p1"}, 32'(id_rdata1_o), 32'(exp));
    check({name, "_p2"}, 32'(id_rdata2_o), 32'(exp));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rw rom reg3 mem alu ra1 ra2 | rd1 rd2 wen waddr wdata cnt(before edge)
    vecs[0]  = '{1'b1, 1'b0, 3'd5, 16'h0000, 16'hBEEF, 3'd5, 3'd0, 16'hBEEF, 16'h0000, 1'b1, 3'd5, 16'hBEEF, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 16'd1};
    vecs[2]  = '{1'b1, 1'b1, 3'd2, 16'h00A5, 16'hFFFF, 3'd2, 3'd5, 16'h00A5, 16'hBEEF, 1'b1, 3'd2, 16'h00A5, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 3'd4, 16'h0000, 16'h1111, 3'd4, 3'd2, 16'h1111, 16'h00A5, 1'b1, 3'd4, 16'h1111, 16'd2};
    vecs[4]  = '{1'b1, 1'b0, 3'd4, 16'h9999, 16'h2222, 3'd4, 3'd4, 16'h2222, 16'h2222, 1'b1, 3'd4, 16'h2222, 16'd3};
    vecs[5]  = '{1'b0, 1'b0, 3'd4, 16'h0000, 16'h0000, 3'd4, 3'd4, 16'h2222, 16'h2222, 1'b0, 3'd4, 16'h0000, 16'd4};
    vecs[6]  = '{1'b1, 1'b1, 3'd0, 16'h0F0F, 16'h1234, 3'd0, 3'd7, 16'h0F0F, 16'h0000, 1'b1, 3'd0, 16'h0F0F, 16'd4};
    vecs[7]  = '{1'b0, 1'b1, 3'd1, 16'hDEAD, 16'hDEAD, 3'd1, 3'd0, 16'h0000, 16'h0F0F, 1'b0, 3'd1, 16'hDEAD, 16'd5};
    vecs[8]  = '{1'b1, 1'b0, 3'd7, 16'h0000, 16'h7001, 3'd7, 3'd7, 16'h7001, 16'h7001, 1'b1, 3'd7, 16'h7001, 16'd5};
    vecs[9]  = '{1'b1, 1'b0, 3'd7, 16'h0000, 16'h7002, 3'd7, 3'd3, 16'h7002, 16'h0000, 1'b1, 3'd7, 16'h7002, 16'd6};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd7, 3'd0, 16'h7002, 16'h0F0F, 1'b0, 3'd0, 16'h0000, 16'd7};

    // Reset held from time zero with a write presented: everything must read zero.
    rst_i = 1'b0;
    drive(1'b1, 1'b1, 3'd3, 16'hAAAA, 16'h5555, 3'd3, 3'd3);
    @(negedge clk_i); #2;
    check("rst_rd1", 32'(id_rdata1_o), 32'h0);
    check("rst_rd2", 32'(id_rdata2_o), 32'h0);
    check("rst_wen", 32'(fwd_wen_o), 32'h0);
    check("rst_waddr", 32'(fwd_waddr_o), 32'h0);
    check("rst_wdata", 32'(fwd_wdata_o), 32'h0);
    check("rst_cnt", 32'(retired_cnt_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    read_reg("rst_nocommit_r3", 3'd3, 16'h0000);

    // Vector table through the scoreboard.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      drive(vecs[i].rw, vecs[i].rom, vecs[i].reg3, vecs[i].mem, vecs[i].alu, vecs[i].ra1, vecs[i].ra2);
      sb.push_back('{i, vecs[i].e_rd1, vecs[i].e_rd2, vecs[i].e_wen, vecs[i].e_waddr,
                     vecs[i].e_wdata, vecs[i].e_cnt});
      #2;
      begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("v%0d_rd1", e.idx), 32'(id_rdata1_o), 32'(e.rd1));
        check($sformatf("v%0d_rd2", e.idx), 32'(id_rdata2_o), 32'(e.rd2));
        check($sformatf("v%0d_wen", e.idx), 32'(fwd_wen_o), 32'(e.wen));
        check($sformatf("v%0d_waddr", e.idx), 32'(fwd_waddr_o), 32'(e.waddr));
        check($sformatf("v%0d_wdata", e.idx), 32'(fwd_wdata_o), 32'(e.wdata));
        check($sformatf("v%0d_cnt", e.idx), 32'(retired_cnt_o), 32'(e.cnt));
      end
    end
    @(negedge clk_i);
    check("table_final_cnt", 32'(retired_cnt_o), 32'd7);
    read_reg("bypass_after_r4", 3'd4, 16'h2222);

    // Idle cycles with a tempting write payload must change nothing.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      drive(1'b0, 1'b1, 3'd1, 16'hDEAD, 16'hDEAD, 3'd1, 3'd1);
      #2;
      check("idle_wen", 32'(fwd_wen_o), 32'h0);
      check("idle_r1", 32'(id_rdata1_o), 32'h0);
    end
    @(negedge clk_i);
    check("idle_cnt", 32'(retired_cnt_o), 32'd7);

    // Write R3 then assert reset mid low-phase; clear must be immediate.
    drive(1'b1, 1'b0, 3'd3, 16'h0000, 16'h1234, 3'd3, 3'd0);
    @(negedge clk_i);
    read_reg("pre_rst_r3", 3'd3, 16'h1234);
    #1;
    rst_i = 1'b0;
    for (int r = 0; r < 8; r++) begin
      read_reg($sformatf("async_rst_r%0d", r), 3'(r), 16'h0000);
    end
    check("async_rst_cnt", 32'(retired_cnt_o), 32'h0);
    drive(1'b1, 1'b0, 3'd3, 16'h0000, 16'h5555, 3'd0, 3'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    read_reg("held_rst_r3", 3'd3, 16'h0000);
    check("held_rst_cnt", 32'(retired_cnt_o), 32'h0);
    drive(1'b1, 1'b0, 3'd6, 16'h0000, 16'h6666, 3'd0, 3'd0);
    @(negedge clk_i);
    read_reg("first_after_rst_r6", 3'd6, 16'h6666);
    check("first_after_rst_cnt", 32'(retired_cnt_o), 32'd1);

    // Counter wrap from a fresh reset.
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b0, 3'(i % 8), 16'h0000, 16'(i), 3'd0, 3'd0);
    end
    @(negedge clk_i);
    check("cnt_ffff", 32'(retired_cnt_o), 32'hFFFF);
    read_reg("wrap_r6", 3'd6, 16'hFFFE);
    drive(1'b1, 1'b1, 3'd0, 16'hC0DE, 16'h0000, 3'd0, 3'd0);
    @(negedge clk_i);
    check("cnt_wrap_0", 32'(retired_cnt_o), 32'h0000);
    drive(1'b1, 1'b1, 3'd0, 16'hC0DF, 16'h0000, 3'd0, 3'd0);
    @(negedge clk_i);
    check("cnt_wrap_1", 32'(retired_cnt_o), 32'h0001);
    read_reg("wrap_r0", 3'd0, 16'hC0DF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (memory data or ALU result) and commits it to an 8 x 16-bit general register file.
- Serves two combinational read ports to the decode stage, with same-cycle write-through bypass.
- Exposes the committed write to the forwarding unit and keeps a free-running retired-write counter.

Parameters:
DATA_W, 16, register and data width
ADDR_W, 3, register index width
NUM_REGS, 8, register count (= 2**ADDR_W)
CNT_W, 16, retired-write counter width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous, active-low reset (0 = reset asserted)
wb_memData_i  in  DATA_W  load data from MEM/WB register
wb_aluResult_i  in  DATA_W  ALU result from MEM/WB register
wb_reg3_i  in  ADDR_W  destination register index
wb_resultOrMem_i  in  1  1 = write memData, 0 = write aluResult
wb_regWrite_i  in  1  write enable
id_raddr1_i  in  ADDR_W  read port 1 index
id_raddr2_i  in  ADDR_W  read port 2 index
id_rdata1_o  out  DATA_W  read port 1 data
id_rdata2_o  out  DATA_W  read port 2 data
fwd_wen_o  out  1  writeback write valid this cycle
fwd_waddr_o  out  ADDR_W  writeback destination index
fwd_wdata_o  out  DATA_W  selected writeback value
retired_cnt_o  out  CNT_W  count of committed register writes

Behaviour:
- Writeback value: wdata = wb_resultOrMem_i ? wb_memData_i : wb_aluResult_i. The select is purely combinational.
- Reset (rst_i = 0):
  - Takes effect immediately, with no clock needed.
  - All NUM_REGS registers become 0 and retired_cnt_o becomes 0.
  - While reset is held, fwd_wen_o = 0, fwd_waddr_o = 0, fwd_wdata_o = 0, id_rdata1_o = 0 and id_rdata2_o = 0.
  - No write commits on any edge during reset.
- Write:
  - On a rising edge with rst_i = 1 and wb_regWrite_i = 1, reg[wb_reg3_i] <= wdata.
  - Latency is 1 cycle to storage.
  - All 8 registers, including R0, are writable. There is no hardwired zero.
- Read:
  - Both ports are combinational from storage, with zero latency.
  - Bypass: if wb_regWrite_i = 1 and id_raddrN_i == wb_reg3_i, then id_rdataN_o = wdata (the value about to be written), not the stale storage value.
  - Both ports may bypass in the same cycle. Both ports may read the same index.
- Forward outputs (when out of reset):
  - fwd_wen_o = wb_regWrite_i.
  - fwd_waddr_o = wb_reg3_i.
  - fwd_wdata_o = wdata.
  - All are combinational, with no added latency.
- Counter:
  - On each committed write edge, retired_cnt_o <= retired_cnt_o + 1.
  - Wraps from all-ones (0xFFFF) to 0 with no sticky flag.
  - No increment when wb_regWrite_i = 0.
- Back-to-back writes to the same index:
  - The last edge wins.
  - Each edge increments the counter.
- Reset deasserting:
  - Deassertion is synchronised by the system. The block assumes rst_i meets recovery to clk_i.
  - The first write edge after release commits normally.
- Inputs with wb_regWrite_i = 0 never alter storage, regardless of the other wb_* values.
- Unknown values on wb_resultOrMem_i while wb_regWrite_i = 0 have no architectural effect.

Test Plan:
- Reset: drive rst_i = 0 mid-cycle after writing R3 = 0x1234 → reads of all 8 regs return 0 immediately; retired_cnt_o = 0.
- ALU write: wb_reg3_i = 5, wb_aluResult_i = 0xBEEF, wb_resultOrMem_i = 0, wb_regWrite_i = 1, one edge → id_raddr1_i = 5 reads 0xBEEF; retired_cnt_o = 1.
- Mem select: wb_memData_i = 0x00A5, wb_aluResult_i = 0xFFFF, wb_resultOrMem_i = 1, write R2 → R2 = 0x00A5; fwd_wdata_o = 0x00A5 during the write cycle.
- Bypass: R4 holds 0x1111; in the same cycle write R4 = 0x2222 with id_raddr1_i = id_raddr2_i = 4 → both read ports show 0x2222 before the edge and after it.
- No-write: wb_regWrite_i = 0, wb_reg3_i = 1, data 0xDEAD for 10 cycles → R1 unchanged; retired_cnt_o unchanged; fwd_wen_o = 0.
- Counter wrap: perform 65536 writes → retired_cnt_o returns to 0x0000; the 65537th write gives 0x0001.
